// File: rtl/maze_ctrl_if.sv
// Maze memory bus: host port, solver port and the shared memory port.
// The slave side is the controller. The master side is the host/solver/memory environment.
interface maze_ctrl_if #(
   parameter int maze_width = 6
);
   logic                  host_req;
   logic [maze_width-1:0] host_row;
   logic [maze_width-1:0] host_col;
   logic                  host_oe;
   logic                  host_we;
   logic                  host_gnt;

   logic [maze_width-1:0] solver_row;
   logic [maze_width-1:0] solver_col;
   logic                  solver_oe;
   logic                  solver_we;
   logic                  solver_done;
   logic                  solver_run;

   logic [maze_width-1:0] mem_row;
   logic [maze_width-1:0] mem_col;
   logic                  mem_oe;
   logic                  mem_we;

   modport master (
      output host_req, host_row, host_col, host_oe, host_we,
      input  host_gnt,
      output solver_row, solver_col, solver_oe, solver_we, solver_done,
      input  solver_run,
      input  mem_row, mem_col, mem_oe, mem_we
   );

   modport slave (
      input  host_req, host_row, host_col, host_oe, host_we,
      output host_gnt,
      input  solver_row, solver_col, solver_oe, solver_we, solver_done,
      output solver_run,
      output mem_row, mem_col, mem_oe, mem_we
   );
endinterface

// File: rtl/maze_ctrl.sv
// Maze solve controller: arbitrates the maze memory between host and solver,
// and times each solve run against a cycle budget.
module maze_ctrl #(
   parameter int                     maze_width    = 6,
   parameter int                     count_width   = 16,
   parameter logic [count_width-1:0] timeout_limit = 16'hFFFF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   maze_ctrl_if.slave             bus,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic                   solved,
   output logic                   timeout,
   output logic [count_width-1:0] cycle_count
);
   typedef enum logic [2:0] {IDLE, HOST, ARM, RUN, FINISH} state_t;

   state_t                 state_q, state_d;
   logic [count_width-1:0] count_q;
   logic                   solved_q, timeout_q;
   logic                   at_limit;
   logic                   gnt, run;
   logic [maze_width-1:0]  row_mux, col_mux;
   logic                   oe_mux, we_mux;

   assign at_limit = (count_q == timeout_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Outputs decode only the registered state, so reset clears them without a clock edge.
   always_comb begin
      state_d = state_q;
      gnt     = 1'b0;
      run     = 1'b0;
      row_mux = '0;
      col_mux = '0;
      oe_mux  = 1'b0;
      we_mux  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.host_req)  state_d = HOST;
            else if (start)    state_d = ARM;
         end
         HOST: begin
            gnt     = 1'b1;
            row_mux = bus.host_row;
            col_mux = bus.host_col;
            oe_mux  = bus.host_oe;
            we_mux  = bus.host_we;
            if (!bus.host_req) state_d = IDLE;
         end
         ARM: state_d = RUN;
         RUN: begin
            run     = 1'b1;
            row_mux = bus.solver_row;
            col_mux = bus.solver_col;
            oe_mux  = bus.solver_oe;
            we_mux  = bus.solver_we;
            if (bus.solver_done || at_limit || abort) state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The final RUN cycle still counts; saturation keeps a timed-out solve at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         solved_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else if (state_q == ARM) begin
         count_q   <= '0;
         solved_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else if (state_q == RUN) begin
         if (!at_limit)            count_q   <= count_q + 1'b1;
         if (bus.solver_done)      solved_q  <= 1'b1;
         else if (at_limit)        timeout_q <= 1'b1;
      end
   end

   assign bus.host_gnt   = gnt;
   assign bus.solver_run = run;
   assign bus.mem_row    = row_mux;
   assign bus.mem_col    = col_mux;
   assign bus.mem_oe     = oe_mux;
   assign bus.mem_we     = we_mux;
   assign busy           = (state_q != IDLE);
   assign solved         = solved_q;
   assign timeout        = timeout_q;
   assign cycle_count    = count_q;
endmodule

// File: tb/tb_maze_ctrl.sv
// Randomized bench for maze_ctrl: two instances (budgets 16 and 8) run in lockstep
// against a transaction-level model of each solve's outcome.
module tb_maze_ctrl;
   localparam int MW = 6;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          host_req, host_oe, host_we;
   logic [MW-1:0] host_row, host_col;
   logic          start, abort;
   logic          solver_oe, solver_we, solver_done;
   logic [MW-1:0] solver_row, solver_col;

   int checks = 0;
   int errors = 0;

   logic          gnt [2], run [2], busy [2], solved [2], tmo [2], moe [2], mwe [2];
   logic [MW-1:0] mrow [2], mcol [2];
   logic [CW-1:0] cnt [2];

   bit            exp_solved [2];
   bit            exp_tmo [2];
   int            exp_cnt [2];

   always #5 clk = ~clk;

   maze_ctrl_if #(.maze_width(MW)) bus0 ();
   maze_ctrl_if #(.maze_width(MW)) bus1 ();

   assign bus0.host_req = host_req;     assign bus1.host_req = host_req;
   assign bus0.host_row = host_row;     assign bus1.host_row = host_row;
   assign bus0.host_col = host_col;     assign bus1.host_col = host_col;
   assign bus0.host_oe  = host_oe;      assign bus1.host_oe  = host_oe;
   assign bus0.host_we  = host_we;      assign bus1.host_we  = host_we;
   assign bus0.solver_row  = solver_row;  assign bus1.solver_row  = solver_row;
   assign bus0.solver_col  = solver_col;  assign bus1.solver_col  = solver_col;
   assign bus0.solver_oe   = solver_oe;   assign bus1.solver_oe   = solver_oe;
   assign bus0.solver_we   = solver_we;   assign bus1.solver_we   = solver_we;
   assign bus0.solver_done = solver_done; assign bus1.solver_done = solver_done;

   assign gnt[0] = bus0.host_gnt;   assign gnt[1] = bus1.host_gnt;
   assign run[0] = bus0.solver_run; assign run[1] = bus1.solver_run;
   assign mrow[0] = bus0.mem_row;   assign mrow[1] = bus1.mem_row;
   assign mcol[0] = bus0.mem_col;   assign mcol[1] = bus1.mem_col;
   assign moe[0] = bus0.mem_oe;     assign moe[1] = bus1.mem_oe;
   assign mwe[0] = bus0.mem_we;     assign mwe[1] = bus1.mem_we;

   maze_ctrl #(.maze_width(MW), .count_width(CW), .timeout_limit(16'd16)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .start(start), .abort(abort),
      .busy(busy[0]), .solved(solved[0]), .timeout(tmo[0]), .cycle_count(cnt[0])
   );

   maze_ctrl #(.maze_width(MW), .count_width(CW), .timeout_limit(16'd8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .start(start), .abort(abort),
      .busy(busy[1]), .solved(solved[1]), .timeout(tmo[1]), .cycle_count(cnt[1])
   );

   function automatic int lim_of(input int i);
      return (i == 0) ? 16 : 8;
   endfunction

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      for (int i = 0; i < 2; i++) begin
         check({tag, "_busy"}, busy[i], 1'b0);
         check({tag, "_gnt"}, gnt[i], 1'b0);
         check({tag, "_run"}, run[i], 1'b0);
         check({tag, "_moe"}, moe[i], 1'b0);
         check({tag, "_mwe"}, mwe[i], 1'b0);
         check({tag, "_mrow"}, mrow[i], '0);
         check({tag, "_mcol"}, mcol[i], '0);
         check({tag, "_solved"}, solved[i], exp_solved[i]);
         check({tag, "_tmo"}, tmo[i], exp_tmo[i]);
         check({tag, "_cnt"}, cnt[i], exp_cnt[i]);
      end
   endtask

   task automatic rand_host_bus();
      host_row = MW'($urandom);
      host_col = MW'($urandom);
      host_oe  = 1'($urandom);
      host_we  = 1'($urandom);
   endtask

   task automatic rand_solver_bus();
      solver_row = MW'($urandom);
      solver_col = MW'($urandom);
      solver_oe  = 1'($urandom);
      solver_we  = 1'($urandom);
   endtask

   // Host session: host_req high for n cycles, then one granted cycle with it low.
   task automatic do_host(input int n, input bit fixed);
      host_req = 1'b1;
      rand_host_bus();
      host_oe = 1'b1;
      host_we = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("host_pre_gnt", gnt[i], 1'b0);
         check("host_pre_mwe", mwe[i], 1'b0);
      end
      for (int j = 1; j <= n; j++) begin
         tick();
         rand_host_bus();
         if (fixed) begin
            host_row = MW'(3);
            host_col = MW'(7);
            host_we  = 1'b1;
         end
         host_req = (j < n);
         #1;
         for (int i = 0; i < 2; i++) begin
            check("host_gnt", gnt[i], 1'b1);
            check("host_run", run[i], 1'b0);
            check("host_busy", busy[i], 1'b1);
            check("host_mrow", mrow[i], host_row);
            check("host_mcol", mcol[i], host_col);
            check("host_moe", moe[i], host_oe);
            check("host_mwe", mwe[i], host_we);
         end
      end
      tick();
      check_idle("host_end");
   endtask

   // Solve with solver_done at RUN cycle d and abort at RUN cycle a (0 = never).
   task automatic do_solve(input int d, input int a, input bit hold_req);
      int e [2];
      bit s [2];
      bit t [2];
      int c [2];
      int maxe, mine;
      for (int i = 0; i < 2; i++) begin
         e[i] = lim_of(i) + 1;
         if (a > 0 && a < e[i]) e[i] = a;
         if (d > 0 && d <= e[i]) e[i] = d;
         s[i] = (d == e[i]);
         t[i] = !s[i] && (e[i] == lim_of(i) + 1);
         c[i] = min2(e[i], lim_of(i));
      end
      maxe = (e[0] > e[1]) ? e[0] : e[1];
      mine = (e[0] < e[1]) ? e[0] : e[1];

      host_req = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("arm_busy", busy[i], 1'b1);
         check("arm_run", run[i], 1'b0);
         check("arm_mwe", mwe[i], 1'b0);
         check("arm_solved_held", solved[i], exp_solved[i]);
         check("arm_tmo_held", tmo[i], exp_tmo[i]);
      end

      for (int k = 1; k <= maxe + 2; k++) begin
         tick();
         solver_done = (k == d);
         abort       = (k == a);
         rand_solver_bus();
         rand_host_bus();
         host_req = hold_req;
         start    = (k <= mine + 1) ? 1'($urandom) : 1'b0;
         #1;
         for (int i = 0; i < 2; i++) begin
            if (k <= e[i]) begin
               check("run_run", run[i], 1'b1);
               check("run_gnt", gnt[i], 1'b0);
               check("run_busy", busy[i], 1'b1);
               check("run_cnt", cnt[i], min2(k - 1, lim_of(i)));
               check("run_solved", solved[i], 1'b0);
               check("run_tmo", tmo[i], 1'b0);
               check("run_mrow", mrow[i], solver_row);
               check("run_mcol", mcol[i], solver_col);
               check("run_moe", moe[i], solver_oe);
               check("run_mwe", mwe[i], solver_we);
            end else if (k == e[i] + 1) begin
               check("fin_run", run[i], 1'b0);
               check("fin_gnt", gnt[i], 1'b0);
               check("fin_busy", busy[i], 1'b1);
               check("fin_moe", moe[i], 1'b0);
               check("fin_mwe", mwe[i], 1'b0);
               check("fin_solved", solved[i], s[i]);
               check("fin_tmo", tmo[i], t[i]);
               check("fin_cnt", cnt[i], c[i]);
            end else if (k == e[i] + 2) begin
               check("post_busy", busy[i], 1'b0);
               check("post_gnt", gnt[i], 1'b0);
            end else begin
               check("late_busy", busy[i], hold_req);
               check("late_gnt", gnt[i], hold_req);
            end
         end
      end
      solver_done = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_solved[i] = s[i];
         exp_tmo[i] = t[i];
         exp_cnt[i] = c[i];
      end
      if (hold_req) begin
         tick();
         for (int i = 0; i < 2; i++) check("deferred_gnt", gnt[i], 1'b1);
         host_req = 1'b0;
         tick();
      end
      check_idle("solve_end");
   endtask

   task automatic collision();
      host_req = 1'b1;
      start = 1'b1;
      rand_host_bus();
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) check("coll_gnt", gnt[i], 1'b1);
      host_req = 1'b0;
      tick();
      tick();
      check_idle("coll_end");
   endtask

   task automatic reset_mid_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      solver_oe = 1'b1;
      solver_we = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) check("rr_pre_run", run[i], 1'b1);
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_solved[i] = 1'b0;
         exp_tmo[i] = 1'b0;
         exp_cnt[i] = 0;
      end
      #1;
      check_idle("rst_run");
      tick();
      rst_n = 1'b1;
      tick();
      check_idle("rst_run_rel");
   endtask

   task automatic reset_mid_host();
      host_req = 1'b1;
      host_oe = 1'b1;
      host_we = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) check("rh_pre_gnt", gnt[i], 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("rst_host");
      host_req = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check_idle("rst_host_rel");
   endtask

   initial begin
      rst_n = 1'b0;
      host_req = 1'b0; host_row = '0; host_col = '0; host_oe = 1'b0; host_we = 1'b0;
      start = 1'b0; abort = 1'b0;
      solver_row = '0; solver_col = '0; solver_oe = 1'b0; solver_we = 1'b0; solver_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_solved[i] = 1'b0;
         exp_tmo[i] = 1'b0;
         exp_cnt[i] = 0;
      end
      #3;
      check_idle("reset");
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      do_host(5, 1'b1);
      do_solve(10, 0, 1'b0);
      do_solve(0, 0, 1'b0);
      collision();
      do_solve(5, 0, 1'b1);
      reset_mid_run();
      reset_mid_host();
      do_solve(9, 9, 1'b0);
      do_solve(0, 9, 1'b0);
      do_solve(0, 3, 1'b0);
      do_solve(1, 0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0:       do_host($urandom_range(1, 6), 1'b0);
            1:       collision();
            default: do_solve(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20),
                              ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 20),
                              1'($urandom));
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/maze_ctrl.md
MAZE_CTRL -- requirements
Module: maze_ctrl

Interface
REQ-001 Parameter maze_width, default 6, SHALL set the row/column coordinate width in bits.
REQ-002 Parameter count_width, default 16, SHALL set the width of cycle_count.
REQ-003 Parameter timeout_limit, default 16'hFFFF, SHALL set the RUN cycle budget.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports, in order:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- host_req  in  1  host requests the maze memory
- host_row, host_col  in  maze_width  host address
- host_oe, host_we  in  1  host read/write enables
- host_gnt  out  1  host owns the memory
- start  in  1  single-cycle pulse, launches a solve
- abort  in  1  terminates a running solve
- solver_row, solver_col  in  maze_width  solver address
- solver_oe, solver_we  in  1  solver read/write enables
- solver_done  in  1  solver reports exit found
- solver_run  out  1  solver enable; solver held idle when 0
- mem_row, mem_col  out  maze_width  memory address
- mem_oe, mem_we  out  1  memory read/write enables
- busy  out  1  state is not IDLE
- solved  out  1  sticky, last solve found exit
- timeout  out  1  sticky, last solve exceeded budget
- cycle_count  out  count_width  RUN cycles of current/last solve

Function
REQ-006 States SHALL be IDLE, HOST, ARM, RUN and FINISH, held in one registered state variable.
REQ-007 IDLE: host_req=1 SHALL go to HOST; otherwise start=1 SHALL go to ARM; otherwise remain in IDLE.
REQ-008 host_req and start both high in IDLE SHALL go to HOST, and that start pulse SHALL be discarded.
REQ-009 start SHALL be ignored in every state except IDLE.
REQ-010 HOST: host_gnt=1; host_req=0 SHALL return to IDLE on the next edge.
REQ-011 ARM SHALL last exactly one cycle, clear cycle_count, solved and timeout, then go to RUN.
REQ-012 RUN: solver_run=1, and cycle_count SHALL increment by 1 per cycle, saturating at timeout_limit.
REQ-013 RUN exits to FINISH with the following priority:
- solver_done=1: set solved.
- else cycle_count==timeout_limit: set timeout.
- else abort=1: set neither flag.
REQ-014 Simultaneous solver_done and limit/abort SHALL resolve to solved=1, timeout=0.
REQ-015 host_req during ARM/RUN/FINISH SHALL NOT be granted; it SHALL be served from IDLE afterwards.
REQ-016 FINISH SHALL last one cycle with solver_run=0, then go to IDLE.
REQ-017 solved, timeout and cycle_count SHALL hold until the next ARM.
REQ-018 Memory mux (combinational from registered state, zero added latency):
- HOST: mem_* = host_*.
- RUN: mem_* = solver_*.
- Any other state: mem_oe=0, mem_we=0, mem_row=0, mem_col=0.
REQ-019 host_gnt and solver_run SHALL never both be 1.
REQ-020 mem_we SHALL never be 1 outside HOST or RUN.
REQ-021 busy SHALL be 1 exactly when state is not IDLE.

Reset
REQ-022 rst_n=0 SHALL immediately force the following, regardless of clk:
- state IDLE
- host_gnt=0, solver_run=0, busy=0
- solved=0, timeout=0, cycle_count=0
- mem_oe=0, mem_we=0, mem_row=0, mem_col=0
REQ-023 Reset asserted mid-RUN or mid-HOST SHALL abandon the operation with no flag set; operation resumes from IDLE after rst_n rises.

Verification
REQ-024 host_req=1 for 5 cycles with host_we=1 at row 3, col 7 -> host_gnt=1 one edge later; mem_we=1, mem_row=3, mem_col=7 while granted; IDLE one edge after host_req falls.
REQ-025 start pulse, solver_done asserted on the 10th RUN cycle -> solver_run high for 10 cycles, solved=1, timeout=0, cycle_count=10, busy low 2 edges after done.
REQ-026 timeout_limit=8, solver_done never asserted -> timeout=1, solved=0, cycle_count=8, solver_run=0 after FINISH.
REQ-027 host_req and start high in same IDLE cycle -> HOST entered, no ARM, solved/timeout unchanged; host_req held through RUN gets no grant until FINISH->IDLE.
REQ-028 rst_n low on 4th RUN cycle -> solver_run, mem_oe, mem_we and cycle_count 0 without a clock edge; solved=timeout=0.
REQ-029 solver_done and abort high on same RUN cycle, count at limit -> solved=1, timeout=0.
